// File: rtl/pcie_dn_pkg.sv
// Shared definitions for the download free-buffer read path: descriptor layout,
// fetch FSM encoding, MRRS decoding and the 4 KB request boundary.
package pcie_dn_pkg;

    localparam int DESC_W        = 96;
    localparam int DESC_ADDR_LSB = 0;
    localparam int DESC_ADDR_W   = 64;
    localparam int DESC_LEN_LSB  = 64;
    localparam int DESC_LEN_W    = 24;
    localparam int DESC_TAG_LSB  = 88;
    localparam int DESC_TAG_W    = 8;

    localparam int CHUNK_W = 13;
    localparam logic [CHUNK_W-1:0] BOUNDARY_4K = 13'h1000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_POP   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_SPLIT = 2'd3;

    // Codes above 5 saturate at 4096 bytes.
    function automatic logic [CHUNK_W-1:0] mrrs_bytes(input logic [2:0] code);
        logic [2:0] sat;
        sat = (code > 3'd5) ? 3'd5 : code;
        return 13'd128 << sat;
    endfunction

endpackage

// File: rtl/pcie_dn_rd_split.sv
// Holds the working address/remainder of one descriptor and emits registered
// read requests bounded by the latched MRRS and the next 4 KB boundary.
module pcie_dn_rd_split
    import pcie_dn_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic [DESC_LEN_W-1:0] load_len,
    input  logic [DESC_TAG_W-1:0] load_tag,
    input  logic [2:0]            load_mrrs,
    input  logic                  ready,
    output logic                  valid,
    output logic [ADDR_W-1:0]     addr,
    output logic [CHUNK_W-1:0]    len,
    output logic [DESC_TAG_W-1:0] tag,
    output logic                  last
);

    logic [DESC_LEN_W-1:0] rem;
    logic [CHUNK_W-1:0]    mrrs;

    logic                  accept;
    logic [ADDR_W-1:0]     nxt_addr;
    logic [DESC_LEN_W-1:0] nxt_rem;
    logic [CHUNK_W-1:0]    nxt_mrrs;
    logic [CHUNK_W-1:0]    room;
    logic [CHUNK_W-1:0]    rem_cap;
    logic [CHUNK_W-1:0]    chunk;
    logic                  nxt_last;

    // The next chunk is computed from either the fresh descriptor or the
    // post-acceptance address/remainder, so it can be registered directly.
    always_comb begin
        accept   = valid & ready;
        nxt_addr = load ? load_addr : addr + ADDR_W'(len);
        nxt_rem  = load ? load_len : rem - DESC_LEN_W'(len);
        nxt_mrrs = load ? mrrs_bytes(load_mrrs) : mrrs;
        room     = BOUNDARY_4K - {1'b0, nxt_addr[11:0]};
        rem_cap  = (nxt_rem > DESC_LEN_W'(BOUNDARY_4K)) ? BOUNDARY_4K : nxt_rem[CHUNK_W-1:0];
        chunk    = rem_cap;
        if (nxt_mrrs < chunk) chunk = nxt_mrrs;
        if (room < chunk)     chunk = room;
        nxt_last = (nxt_rem == DESC_LEN_W'(chunk));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            len   <= '0;
            tag   <= '0;
            last  <= 1'b0;
            rem   <= '0;
            mrrs  <= '0;
        end else if (load || (accept && !last)) begin
            valid <= 1'b1;
            addr  <= nxt_addr;
            len   <= chunk;
            last  <= nxt_last;
            rem   <= nxt_rem;
            mrrs  <= nxt_mrrs;
            if (load) tag <= load_tag;
        end else if (accept) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pcie_dn_fbuf_rd.sv
// Download free-buffer consumer: fetch FSM popping descriptors and driving the splitter.
// Define PCIE_DN_FBUF_RD_STAT_EN to add the STAT_* descriptor/request/error counters.
module pcie_dn_fbuf_rd
    import pcie_dn_pkg::*;
#(
    parameter int FBUF_RD_LAT = 3,
    parameter int ADDR_W      = 64
) (
    input  logic               PCIE_CLK,
    input  logic               PCIE_RST,
    input  logic               CFG_EN,
    input  logic [2:0]         CFG_MRRS,
    input  logic               DN_FBUF_RD_RDY,
    output logic               DN_FBUF_RD_REQ,
    input  logic [DESC_W-1:0]  DN_FBUF_RD_DATA,
    output logic               REQ_VALID,
    input  logic               REQ_READY,
    output logic [ADDR_W-1:0]  REQ_ADDR,
    output logic [12:0]        REQ_LEN,
    output logic [7:0]         REQ_TAG,
    output logic               REQ_LAST,
    output logic               DESC_ERR
`ifdef PCIE_DN_FBUF_RD_STAT_EN
    ,
    output logic [31:0]        STAT_DESC_CNT,
    output logic [31:0]        STAT_REQ_CNT,
    output logic [15:0]        STAT_ERR_CNT
`endif
);

    logic [1:0]            state;
    logic [7:0]            wait_cnt;
    logic [ADDR_W-1:0]     desc_addr;
    logic [DESC_LEN_W-1:0] desc_len;
    logic [DESC_TAG_W-1:0] desc_tag;
    logic                  capture;
    logic                  bad;
    logic                  load;
    logic                  done;

    always_comb begin
        desc_addr      = DN_FBUF_RD_DATA[DESC_ADDR_LSB +: ADDR_W];
        desc_len       = DN_FBUF_RD_DATA[DESC_LEN_LSB +: DESC_LEN_W];
        desc_tag       = DN_FBUF_RD_DATA[DESC_TAG_LSB +: DESC_TAG_W];
        capture        = (state == ST_WAIT) && (wait_cnt == 8'(FBUF_RD_LAT - 1));
        bad            = (desc_len == '0) || (desc_len[1:0] != 2'b00) || (desc_addr[1:0] != 2'b00);
        load           = capture && !bad;
        done           = REQ_VALID && REQ_READY && REQ_LAST;
        DN_FBUF_RD_REQ = (state == ST_POP);
    end

    // RDY is only looked at in IDLE, by which time it reflects the previous pop.
    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            DESC_ERR <= 1'b0;
        end else begin
            DESC_ERR <= 1'b0;
            case (state)
                ST_IDLE: if (CFG_EN && DN_FBUF_RD_RDY) state <= ST_POP;
                ST_POP: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (capture) begin
                        if (bad) begin
                            DESC_ERR <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            state <= ST_SPLIT;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_SPLIT: if (done) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    pcie_dn_rd_split #(
        .ADDR_W(ADDR_W)
    ) u_split (
        .clk       (PCIE_CLK),
        .rst       (PCIE_RST),
        .load      (load),
        .load_addr (desc_addr),
        .load_len  (desc_len),
        .load_tag  (desc_tag),
        .load_mrrs (CFG_MRRS),
        .ready     (REQ_READY),
        .valid     (REQ_VALID),
        .addr      (REQ_ADDR),
        .len       (REQ_LEN),
        .tag       (REQ_TAG),
        .last      (REQ_LAST)
    );

`ifdef PCIE_DN_FBUF_RD_STAT_EN
    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST) begin
            STAT_DESC_CNT <= '0;
            STAT_REQ_CNT  <= '0;
            STAT_ERR_CNT  <= '0;
        end else begin
            if (done)                    STAT_DESC_CNT <= STAT_DESC_CNT + 32'd1;
            if (REQ_VALID && REQ_READY)  STAT_REQ_CNT  <= STAT_REQ_CNT + 32'd1;
            if (capture && bad)          STAT_ERR_CNT  <= STAT_ERR_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pcie_dn_fbuf_rd.sv
// Scoreboard bench for pcie_dn_fbuf_rd with a latency-accurate free-buffer FIFO model.
// Statistics checks are compiled in when PCIE_DN_FBUF_RD_STAT_EN is defined.
module tb_pcie_dn_fbuf_rd;

    localparam int LAT = 3;

    typedef struct {
        logic [63:0] addr;
        logic [12:0] len;
        logic [7:0]  tag;
        logic        last;
    } exp_t;

    logic        PCIE_CLK = 1'b0;
    logic        PCIE_RST;
    logic        CFG_EN;
    logic [2:0]  CFG_MRRS;
    logic        DN_FBUF_RD_RDY;
    logic        DN_FBUF_RD_REQ;
    logic [95:0] DN_FBUF_RD_DATA;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [63:0] REQ_ADDR;
    logic [12:0] REQ_LEN;
    logic [7:0]  REQ_TAG;
    logic        REQ_LAST;
    logic        DESC_ERR;
`ifdef PCIE_DN_FBUF_RD_STAT_EN
    logic [31:0] STAT_DESC_CNT;
    logic [31:0] STAT_REQ_CNT;
    logic [15:0] STAT_ERR_CNT;
`endif

    pcie_dn_fbuf_rd #(
        .FBUF_RD_LAT(LAT),
        .ADDR_W     (64)
    ) dut (
        .PCIE_CLK       (PCIE_CLK),
        .PCIE_RST       (PCIE_RST),
        .CFG_EN         (CFG_EN),
        .CFG_MRRS       (CFG_MRRS),
        .DN_FBUF_RD_RDY (DN_FBUF_RD_RDY),
        .DN_FBUF_RD_REQ (DN_FBUF_RD_REQ),
        .DN_FBUF_RD_DATA(DN_FBUF_RD_DATA),
        .REQ_VALID      (REQ_VALID),
        .REQ_READY      (REQ_READY),
        .REQ_ADDR       (REQ_ADDR),
        .REQ_LEN        (REQ_LEN),
        .REQ_TAG        (REQ_TAG),
        .REQ_LAST       (REQ_LAST),
        .DESC_ERR       (DESC_ERR)
`ifdef PCIE_DN_FBUF_RD_STAT_EN
        ,
        .STAT_DESC_CNT  (STAT_DESC_CNT),
        .STAT_REQ_CNT   (STAT_REQ_CNT),
        .STAT_ERR_CNT   (STAT_ERR_CNT)
`endif
    );

    always #5 PCIE_CLK = ~PCIE_CLK;

    int checks = 0;
    int errors = 0;

    exp_t        sb[$];
    logic [95:0] fifo_q[$];

    int cyc      = 0;
    int pop_cnt  = 0;
    int err_seen = 0;
    int acc_cnt  = 0;
    logic req_seen = 1'b0;

    function automatic logic [95:0] mk(input logic [63:0] a, input logic [23:0] l, input logic [7:0] t);
        return {t, l, a};
    endfunction

    task automatic expect_req(input logic [63:0] a, input logic [12:0] l, input logic [7:0] t, input logic lst);
        exp_t e;
        e.addr = a; e.len = l; e.tag = t; e.last = lst;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge PCIE_CLK);
        #2;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || REQ_VALID) && n < 400) begin
            cycles(1);
            n++;
        end
        chk({name, "_drain_left"}, 64'(sb.size()), 64'd0);
        cycles(2);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!REQ_VALID && n < 60) begin
            cycles(1);
            n++;
        end
        chk({name, "_valid_seen"}, 64'(REQ_VALID), 64'd1);
    endtask

    // Free-buffer FIFO model: data appears exactly LAT cycles after the pop,
    // RDY trails the occupancy by two cycles.
    initial begin : fifo_model
        logic [95:0] pipe[LAT];
        logic        r1;
        r1 = 1'b0;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        DN_FBUF_RD_RDY  = 1'b0;
        DN_FBUF_RD_DATA = '0;
        forever begin
            @(posedge PCIE_CLK);
            #1;
            if (PCIE_RST) begin
                for (int i = 0; i < LAT; i++) pipe[i] = '0;
                r1 = 1'b0;
                DN_FBUF_RD_RDY = 1'b0;
            end else begin
                for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
                pipe[0] = (req_seen && fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
                DN_FBUF_RD_RDY = r1;
                r1 = (fifo_q.size() > 0);
            end
            DN_FBUF_RD_DATA = pipe[LAT-1];
        end
    end

    initial begin : monitor
        logic        stall_prev;
        logic        valid_prev;
        int          last_pop;
        int          pop_cyc;
        logic [63:0] h_addr;
        logic [12:0] h_len;
        logic [7:0]  h_tag;
        logic        h_last;
        exp_t        e;
        stall_prev = 1'b0; valid_prev = 1'b0; last_pop = -1; pop_cyc = 0;
        h_addr = '0; h_len = '0; h_tag = '0; h_last = 1'b0;
        forever begin
            @(negedge PCIE_CLK);
            cyc++;
            req_seen = DN_FBUF_RD_REQ;
            if (PCIE_RST) begin
                stall_prev = 1'b0; valid_prev = 1'b0; last_pop = -1;
            end else begin
                if (DN_FBUF_RD_REQ) begin
                    pop_cnt++;
                    if (last_pop >= 0) begin
                        checks++;
                        if (cyc - last_pop < LAT + 2) begin
                            errors++;
                            $display("FAIL pop_spacing: got %0d cycles, required >= %0d", cyc - last_pop, LAT + 2);
                        end
                    end
                    last_pop = cyc;
                    pop_cyc  = cyc;
                end
                if (REQ_VALID && !valid_prev) begin
                    checks++;
                    if (cyc - pop_cyc != LAT + 1) begin
                        errors++;
                        $display("FAIL pop_to_valid: got %0d cycles, required %0d", cyc - pop_cyc, LAT + 1);
                    end
                end
                if (stall_prev && REQ_VALID) begin
                    checks++;
                    if (REQ_ADDR !== h_addr || REQ_LEN !== h_len || REQ_TAG !== h_tag || REQ_LAST !== h_last) begin
                        errors++;
                        $display("FAIL hold: got %h/%h/%h/%b, required %h/%h/%h/%b",
                                 REQ_ADDR, REQ_LEN, REQ_TAG, REQ_LAST, h_addr, h_len, h_tag, h_last);
                    end
                end
                if (stall_prev && !REQ_VALID) begin
                    checks++;
                    errors++;
                    $display("FAIL hold_valid: got REQ_VALID=0 while stalled, required 1");
                end
                if (DESC_ERR) err_seen++;
                if (REQ_VALID && REQ_READY) begin
                    acc_cnt++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL req_unexpected: got addr=%h len=%h tag=%h, required no request",
                                 REQ_ADDR, REQ_LEN, REQ_TAG);
                    end else begin
                        e = sb.pop_front();
                        if (REQ_ADDR !== e.addr || REQ_LEN !== e.len || REQ_TAG !== e.tag || REQ_LAST !== e.last) begin
                            errors++;
                            $display("FAIL req: got addr=%h len=%h tag=%h last=%b, required addr=%h len=%h tag=%h last=%b",
                                     REQ_ADDR, REQ_LEN, REQ_TAG, REQ_LAST, e.addr, e.len, e.tag, e.last);
                        end
                    end
                end
                stall_prev = REQ_VALID && !REQ_READY;
                valid_prev = REQ_VALID && !(REQ_READY && REQ_LAST);
                h_addr = REQ_ADDR; h_len = REQ_LEN; h_tag = REQ_TAG; h_last = REQ_LAST;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs(input string name);
        chk({name, "_rd_req"},   64'(DN_FBUF_RD_REQ), 64'd0);
        chk({name, "_valid"},    64'(REQ_VALID),      64'd0);
        chk({name, "_addr"},     REQ_ADDR,            64'd0);
        chk({name, "_len"},      64'(REQ_LEN),        64'd0);
        chk({name, "_tag"},      64'(REQ_TAG),        64'd0);
        chk({name, "_last"},     64'(REQ_LAST),       64'd0);
        chk({name, "_desc_err"}, 64'(DESC_ERR),       64'd0);
    endtask

    initial begin : stimulus
        int n;
        int base;
        PCIE_RST  = 1'b1;
        CFG_EN    = 1'b0;
        CFG_MRRS  = 3'd0;
        REQ_READY = 1'b0;
        #22;
        check_reset_outputs("reset");
        @(negedge PCIE_CLK); #2;
        PCIE_RST = 1'b0;
        cycles(3);

        // Basic split across a 4 KB boundary with 512-byte MRRS.
        CFG_EN = 1'b1; CFG_MRRS = 3'd2; REQ_READY = 1'b1;
        expect_req(64'h1000_0F80, 13'h080, 8'h5A, 1'b0);
        expect_req(64'h1000_1000, 13'h200, 8'h5A, 1'b0);
        expect_req(64'h1000_1200, 13'h180, 8'h5A, 1'b1);
        fifo_q.push_back(mk(64'h1000_0F80, 24'h400, 8'h5A));
        drain("basic");

        // Two malformed descriptors: zero length, then misaligned address.
        base = err_seen;
        fifo_q.push_back(mk(64'h3000_0000, 24'h000, 8'hE1));
        fifo_q.push_back(mk(64'h3000_0002, 24'h100, 8'hE2));
        n = 0;
        while (err_seen < base + 2 && n < 80) begin cycles(1); n++; end
        cycles(4);
        chk("drop_err_count", 64'(err_seen - base), 64'd2);
        chk("drop_no_req", 64'(sb.size()), 64'd0);
`ifdef PCIE_DN_FBUF_RD_STAT_EN
        chk("stat_desc", 64'(STAT_DESC_CNT), 64'd1);
        chk("stat_req",  64'(STAT_REQ_CNT),  64'd3);
        chk("stat_err",  64'(STAT_ERR_CNT),  64'd2);
`endif

        // Single 4096-byte request.
        CFG_MRRS = 3'd5;
        expect_req(64'h2000_0000, 13'h1000, 8'h11, 1'b1);
        fifo_q.push_back(mk(64'h2000_0000, 24'h1000, 8'h11));
        drain("max");

        // Code 7 saturates at 4096; 4 KB boundary limits the first chunk.
        CFG_MRRS = 3'd7;
        expect_req(64'h5000_0800, 13'h0800, 8'h77, 1'b0);
        expect_req(64'h5000_1000, 13'h1000, 8'h77, 1'b1);
        fifo_q.push_back(mk(64'h5000_0800, 24'h1800, 8'h77));
        drain("mrrs7");

        // Backpressure mid-split; MRRS change must not affect the live descriptor.
        CFG_MRRS = 3'd0;
        for (int i = 0; i < 12; i++)
            expect_req(64'h4000_0000 + 64'(i * 128), 13'h080, 8'h33, (i == 11));
        fifo_q.push_back(mk(64'h4000_0000, 24'h600, 8'h33));
        base = acc_cnt;
        n = 0;
        while (acc_cnt < base + 3 && n < 60) begin cycles(1); n++; end
        chk("bp_started", 64'(acc_cnt >= base + 3), 64'd1);
        REQ_READY = 1'b0;
        CFG_MRRS  = 3'd5;
        cycles(10);
        REQ_READY = 1'b1;
        drain("bp");

        // CFG_EN dropped mid-descriptor: finish it, issue no further pop.
        CFG_MRRS  = 3'd2;
        REQ_READY = 1'b0;
        CFG_EN    = 1'b1;
        expect_req(64'h6000_0000, 13'h200, 8'hA1, 1'b0);
        expect_req(64'h6000_0200, 13'h100, 8'hA1, 1'b1);
        fifo_q.push_back(mk(64'h6000_0000, 24'h300, 8'hA1));
        fifo_q.push_back(mk(64'h7000_0000, 24'h080, 8'hB2));
        wait_valid("en");
        CFG_EN = 1'b0;
        base = pop_cnt;
        REQ_READY = 1'b1;
        drain("en");
        cycles(30);
        chk("en_no_pop", 64'(pop_cnt - base), 64'd0);

        // Asynchronous reset while a request is stalled.
        REQ_READY = 1'b0;
        CFG_EN    = 1'b1;
        wait_valid("rst");
        @(negedge PCIE_CLK); #2;
        PCIE_RST = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        sb.delete();
        fifo_q.delete();
        cycles(3);
        @(negedge PCIE_CLK); #2;
        PCIE_RST  = 1'b0;
        REQ_READY = 1'b1;
        base = pop_cnt;
        cycles(20);
        chk("post_rst_no_pop", 64'(pop_cnt - base), 64'd0);
        chk("post_rst_valid", 64'(REQ_VALID), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_dn_fbuf_rd.md
# pcie_dn_fbuf_rd

Download-path consumer of the free-buffer descriptor queue. It pops 96-bit descriptors from the download free-buffer FIFO through its registered read port (RDY/REQ/DATA). It splits each descriptor into PCIe memory-read requests bounded by the max read request size (MRRS) and 4 KB boundaries, and hands them to the download DMA request engine. It sits between the free-buffer queue and the TLP read-request generator, in the PCIE_CLK domain.

## Interface
Parameters:
- FBUF_RD_LAT, 3: cycles from DN_FBUF_RD_REQ pulse to valid DN_FBUF_RD_DATA.
- ADDR_W, 64: host address width.

Ports:
- PCIE_CLK  in  1  clock. One clock; reset is asynchronous and active-high.
- PCIE_RST  in  1  asynchronous, active-high reset.
- CFG_EN  in  1  enables descriptor fetch. When low, the block finishes its current descriptor, then idles.
- CFG_MRRS  in  3  MRRS code: bytes = 128 << code. Legal codes 0..5; codes 6 and 7 are treated as 5.
- DN_FBUF_RD_RDY  in  1  queue non-empty (registered, lagging).
- DN_FBUF_RD_REQ  out  1  single-cycle pop pulse.
- DN_FBUF_RD_DATA  in  96  descriptor: [63:0] host addr, [87:64] length in bytes, [95:88] tag.
- REQ_VALID  out  1  read request valid.
- REQ_READY  in  1  DMA engine accepts the request.
- REQ_ADDR  out  64  request address.
- REQ_LEN  out  13  request bytes, 4..4096.
- REQ_TAG  out  8  descriptor tag.
- REQ_LAST  out  1  last request of the descriptor.
- DESC_ERR  out  1  one-cycle pulse when a descriptor is dropped.

## Operation
- FSM states: IDLE, POP, WAIT, SPLIT.
- IDLE -> POP: when CFG_EN=1 and DN_FBUF_RD_RDY=1.
- POP: asserts DN_FBUF_RD_REQ for exactly one cycle, then moves to WAIT.
- WAIT: counts FBUF_RD_LAT-1 cycles, then captures DN_FBUF_RD_DATA into addr/rem/tag registers and latches CFG_MRRS. Next state is SPLIT, or IDLE with a DESC_ERR pulse.
- Drop rule: the descriptor is dropped (DESC_ERR, return to IDLE) if the length is 0, or if length[1:0]≠0, or if addr[1:0]≠0.
- SPLIT: chunk = min(rem, MRRS, 0x1000 − addr[11:0]). REQ_LEN = chunk. REQ_LAST = (rem == chunk).
- On each accepted request (REQ_VALID & REQ_READY): addr += chunk, rem −= chunk. After the last request, the FSM returns to IDLE.
- Arithmetic: rem is 24-bit unsigned and the address adder is 64-bit. Chunk is computed in 13 bits; a value of 4096 requires bit 12.
- DN_FBUF_RD_RDY is only sampled in IDLE. Because RDY lags a pop by 2 cycles, sampling it only after capture is always safe.

## Timing
- Reset values: DN_FBUF_RD_REQ=0, REQ_VALID=0, REQ_ADDR=0, REQ_LEN=0, REQ_TAG=0, REQ_LAST=0, DESC_ERR=0, FSM=IDLE.
- Pop latency: RD_REQ at cycle T, data captured at T+FBUF_RD_LAT, REQ_VALID at T+FBUF_RD_LAT+1.
- Minimum spacing between consecutive RD_REQ pulses: FBUF_RD_LAT+2 cycles.
- REQ_* outputs are registered and held stable while REQ_VALID=1 and REQ_READY=0. The next chunk appears the cycle after acceptance, giving one request per cycle when READY is held high.
- CFG_MRRS changes apply only at the next descriptor capture.
- CFG_EN falling mid-descriptor: splitting continues to completion, and no new pop is issued.
- Reset mid-operation: the in-flight descriptor is discarded (the queue shares PCIE_RST and is flushed too).

## Configuration
- PCIE_DN_FBUF_RD_STAT_EN defined: adds output STAT_DESC_CNT[31:0] (descriptors completed), STAT_REQ_CNT[31:0] (requests accepted) and STAT_ERR_CNT[15:0] (descriptors dropped).
  - All three counters wrap, reset to 0, and increment on the same cycle as their event.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package (pcie_dn_pkg) holds:
  - descriptor field offsets and widths;
  - the FSM state encoding;
  - the MRRS code-to-bytes function;
  - the constant 4 KB boundary.
- One sub-module, pcie_dn_rd_split, holds the addr/rem registers, the chunk computation and the REQ_* output registers. The top level holds the fetch FSM and the statistics.

## Test plan
- Basic split: descriptor addr=0x1000_0F80, len=0x400, tag=0x5A, MRRS code 2, READY=1.
  - Expect requests (0x1000_0F80, 0x080), (0x1000_1000, 0x200), (0x1000_1200, 0x180, LAST=1), all with tag 0x5A.
- Single request at maximum size: addr=0x2000_0000, len=0x1000, code 5.
  - Expect one request, LEN=4096, LAST=1.
- Drop: descriptor len=0, then a descriptor with addr=0x...0002.
  - Expect two DESC_ERR pulses, no REQ_VALID, and RD_REQ pulses spaced ≥5 cycles.
- Backpressure: READY held low for 10 cycles mid-split.
  - REQ_* stable throughout; no address skip after READY rises.
- Enable and reset: CFG_EN dropped mid-descriptor, then PCIE_RST asserted mid-split.
  - With CFG_EN low: the current descriptor completes and no further RD_REQ is issued.
  - On reset: all outputs reach reset values immediately (asynchronously).
- Statistics (with PCIE_DN_FBUF_RD_STAT_EN): after the basic-split and drop cases, DESC=1, REQ=3, ERR=2.
